// File: rtl/imem_loader_if.sv
// Stream-in / imem-write bus between the boot source, the loader and instruction memory.
// master: the byte source and memory side; slave: the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words and writes imem.
// Define IMEM_LOADER_CHKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader #(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   word_count,
    imem_loader_if.slave bus,
    output logic         core_hold,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam logic [7:0]        MAX_WC = 8'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] WSTEP  = ADDR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
`ifdef IMEM_LOADER_CHKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        word_cnt_q, word_cnt_d;
    logic [7:0]        wc_q, wc_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              we_q, we_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    logic              accept;

    assign accept = bus.rx_valid && rx_ready_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        wc_d       = wc_q;
        asm_d      = asm_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        rx_ready_d = rx_ready_q;
        we_d       = 1'b0;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef IMEM_LOADER_CHKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (word_count == 8'd0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        // An empty load still carries its (zero) checksum byte
                        state_d    = S_CHK;
                        csum_d     = 8'h00;
                        rx_ready_d = 1'b1;
                        busy_d     = 1'b1;
                        hold_d     = 1'b1;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        hold_d  = 1'b0;
`endif
                    end else if (word_count > MAX_WC) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                        hold_d  = 1'b1;
                    end else begin
                        state_d    = S_RECV;
                        wc_d       = word_count;
                        waddr_d    = '0;
                        byte_cnt_d = 2'd0;
                        word_cnt_d = 8'd0;
                        asm_d      = '0;
                        rx_ready_d = 1'b1;
                        busy_d     = 1'b1;
                        hold_d     = 1'b1;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
                        csum_d     = 8'h00;
`endif
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                    csum_d     = csum_q ^ bus.rx_data;
`endif
                    case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = bus.rx_data;
                        2'd1: asm_d[15:8]  = bus.rx_data;
                        2'd2: asm_d[23:16] = bus.rx_data;
                        default: begin
                            // Output data only changes here, so it holds outside WRITE
                            wdata_d    = {bus.rx_data, asm_q};
                            we_d       = 1'b1;
                            rx_ready_d = 1'b0;
                            state_d    = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + 8'd1;
                if (word_cnt_d == wc_q) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                    state_d    = S_CHK;
                    rx_ready_d = 1'b1;
`else
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
`endif
                end else begin
                    // Address only advances when another word follows, leaving the last one visible
                    waddr_d    = waddr_q + WSTEP;
                    rx_ready_d = 1'b1;
                    state_d    = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK: begin
                if (accept) begin
                    rx_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    if (bus.rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 8'd0;
            wc_q       <= 8'd0;
            asm_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            wc_q       <= wc_d;
            asm_q      <= asm_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign core_hold      = hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
endmodule
